// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel timer/capture block.
package timer_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/multi_timer_capture_if.sv
// Control/status bundle between stimulus logic and multi_timer_capture.
interface multi_timer_capture_if #(
  parameter int W  = 32,
  parameter int N  = 10,
  parameter int PW = 16
);
  logic [PW-1:0]  prescale;
  logic [N-1:0]   start;
  logic [N-1:0]   stop;
  logic [N-1:0]   capture;
  logic [N-1:0]   rst_capture;
  logic [N-1:0]   mode;
  logic [N-1:0]   alarm_en;
  logic [W*N-1:0] alarm;
  logic [N-1:0]   cap_pop;
  logic [W*N-1:0] counter;
  logic [W*N-1:0] captured;
  logic [N-1:0]   cap_valid;
  logic [N-1:0]   cap_overflow;
  logic [N-1:0]   alarm_out;
  logic [N-1:0]   running;

  modport master (
    output prescale, start, stop, capture, rst_capture, mode, alarm_en, alarm, cap_pop,
    input  counter, captured, cap_valid, cap_overflow, alarm_out, running
  );

  modport slave (
    input  prescale, start, stop, capture, rst_capture, mode, alarm_en, alarm, cap_pop,
    output counter, captured, cap_valid, cap_overflow, alarm_out, running
  );
endinterface

// File: rtl/timer_capture_fifo.sv
// Per-channel capture queue; head is visible while valid, push+pop together keeps occupancy.
module timer_capture_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_an,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign valid = (count_q != '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign head  = valid ? mem[rd_ptr_q] : '0;

  always_comb begin
    pop_ok   = pop && valid;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/multi_timer_capture.sv
// N-channel timer with shared prescaler, one-shot/periodic alarms and capture path.
// Define CAPTURE_FIFO_EN for a CAP_DEPTH-entry capture queue per channel instead of a single register.
module multi_timer_capture
  import timer_pkg::*;
#(
  parameter int TIMER_BITWIDTH = 32,
  parameter int NB_INTERFACES  = 10,
  parameter int PRESCALE_W     = 16,
  parameter int CAP_DEPTH      = 4
) (
  input logic                  clk,
  input logic                  rst_an,
  multi_timer_capture_if.slave bus
);
  localparam int W = TIMER_BITWIDTH;
  localparam int N = NB_INTERFACES;

  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d, presc_reload_q, presc_reload_d;
  logic                  tick;

  // The reload value is latched at each wrap so a new prescale never truncates a period.
  always_comb begin
    tick           = (presc_cnt_q == presc_reload_q);
    presc_cnt_d    = presc_cnt_q + PRESCALE_W'(1);
    presc_reload_d = presc_reload_q;
    if (tick) begin
      presc_cnt_d    = '0;
      presc_reload_d = bus.prescale;
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      presc_cnt_q    <= '0;
      presc_reload_q <= '0;
    end else begin
      presc_cnt_q    <= presc_cnt_d;
      presc_reload_q <= presc_reload_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : gen_ch
      ch_state_e    state_q, state_d;
      logic [W-1:0] counter_q, counter_d, counter_inc, alarm_val;
      logic         alarm_out_q, alarm_out_d;
      logic         ovf_q, ovf_d;

      assign alarm_val = bus.alarm[gi*W +: W];

      always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        alarm_out_d = 1'b0;
        counter_inc = counter_q + W'(1);
        if (bus.start[gi]) begin
          state_d   = CH_RUN;
          counter_d = '0;
        end else if (state_q == CH_RUN) begin
          if (bus.stop[gi]) begin
            state_d = CH_IDLE;
          end else if (tick) begin
            counter_d = counter_inc;
            if (bus.alarm_en[gi] && (counter_inc == alarm_val)) begin
              alarm_out_d = 1'b1;
              if (bus.mode[gi] == MODE_PERIODIC) counter_d = '0;
              else                               state_d   = CH_DONE;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
          state_q     <= CH_IDLE;
          counter_q   <= '0;
          alarm_out_q <= 1'b0;
          ovf_q       <= 1'b0;
        end else begin
          state_q     <= state_d;
          counter_q   <= counter_d;
          alarm_out_q <= alarm_out_d;
          ovf_q       <= ovf_d;
        end
      end

`ifdef CAPTURE_FIFO_EN
      logic [W-1:0] fifo_head;
      logic         fifo_valid, fifo_full;

      timer_capture_fifo #(
        .W     (W),
        .DEPTH (CAP_DEPTH)
      ) u_fifo (
        .clk    (clk),
        .rst_an (rst_an),
        .clr    (bus.rst_capture[gi]),
        .push   (bus.capture[gi]),
        .pop    (bus.cap_pop[gi]),
        .din    (counter_q),
        .head   (fifo_head),
        .valid  (fifo_valid),
        .full   (fifo_full)
      );

      always_comb begin
        ovf_d = ovf_q;
        if (bus.rst_capture[gi]) ovf_d = 1'b0;
        else if (bus.capture[gi] && fifo_full && !bus.cap_pop[gi]) ovf_d = 1'b1;
      end

      assign bus.captured[gi*W +: W] = fifo_head;
      assign bus.cap_valid[gi]       = fifo_valid;
`else
      logic [W-1:0] cap_q, cap_d;
      logic         cap_valid_q, cap_valid_d;

      // A capture that lands on an unconsumed entry overwrites it and flags the loss.
      always_comb begin
        cap_d       = cap_q;
        cap_valid_d = cap_valid_q;
        ovf_d       = ovf_q;
        if (bus.rst_capture[gi]) begin
          cap_valid_d = 1'b0;
          ovf_d       = 1'b0;
        end else if (bus.capture[gi]) begin
          cap_d       = counter_q;
          cap_valid_d = 1'b1;
          if (cap_valid_q && !bus.cap_pop[gi]) ovf_d = 1'b1;
        end else if (bus.cap_pop[gi]) begin
          cap_valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
          cap_q       <= '0;
          cap_valid_q <= 1'b0;
        end else begin
          cap_q       <= cap_d;
          cap_valid_q <= cap_valid_d;
        end
      end

      assign bus.captured[gi*W +: W] = cap_q;
      assign bus.cap_valid[gi]       = cap_valid_q;
`endif

      assign bus.counter[gi*W +: W] = counter_q;
      assign bus.cap_overflow[gi]   = ovf_q;
      assign bus.alarm_out[gi]      = alarm_out_q;
      assign bus.running[gi]        = (state_q == CH_RUN);
    end
  endgenerate
endmodule

// File: tb/tb_multi_timer_capture.sv
// Directed bench for multi_timer_capture (8-bit counters, 4 channels so counter wrap is reachable).
module tb_multi_timer_capture;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int PW = 16;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst_an = 1'b0;
  always #5 clk = ~clk;

  multi_timer_capture_if #(.W(W), .N(N), .PW(PW)) bus ();

  multi_timer_capture #(
    .TIMER_BITWIDTH (W),
    .NB_INTERFACES  (N),
    .PRESCALE_W     (PW),
    .CAP_DEPTH      (D)
  ) dut (
    .clk    (clk),
    .rst_an (rst_an),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctr(input int i);
    return 32'(bus.counter[i*W +: W]);
  endfunction

  function automatic logic [31:0] cap(input int i);
    return 32'(bus.captured[i*W +: W]);
  endfunction

  task automatic clear_pulses();
    bus.start       = '0;
    bus.stop        = '0;
    bus.capture     = '0;
    bus.rst_capture = '0;
    bus.cap_pop     = '0;
  endtask

  initial begin
    clear_pulses();
    bus.prescale = '0;
    bus.mode     = '0;
    bus.alarm_en = '0;
    bus.alarm    = '0;

    // Reset state
    step(3);
    check("rst_counter", 32'(bus.counter), 0);
    check("rst_running", 32'(bus.running), 0);
    check("rst_valid", 32'(bus.cap_valid), 0);
    check("rst_captured", 32'(bus.captured), 0);
    check("rst_alarm", 32'(bus.alarm_out), 0);
    rst_an = 1'b1;
    step(1);

    // Basic count and capture on ch0, prescale=0
    bus.start[0] = 1'b1; step(); clear_pulses();
    check("t1_start_ctr", ctr(0), 0);
    check("t1_running", 32'(bus.running[0]), 1);
    step(5);
    check("t1_ctr5", ctr(0), 5);
    bus.capture[0] = 1'b1; step(); clear_pulses();
    check("t1_captured", cap(0), 5);
    check("t1_valid", 32'(bus.cap_valid[0]), 1);
    check("t1_ctr_after_cap", ctr(0), 6);
    bus.cap_pop[0] = 1'b1; step(); clear_pulses();
    check("t1_pop_valid", 32'(bus.cap_valid[0]), 0);
    bus.stop[0] = 1'b1; step(); clear_pulses();
    check("stop_running", 32'(bus.running[0]), 0);
    step(3);
    check("stop_held", ctr(0), 7);

    // start+capture same cycle, start+stop same cycle, single-register overflow
    bus.start[0] = 1'b1; bus.capture[0] = 1'b1; step(); clear_pulses();
    check("t5_captured_old", cap(0), 7);
    check("t5_ctr_restart", ctr(0), 0);
    check("t5_no_ovf", 32'(bus.cap_overflow[0]), 0);
    bus.start[0] = 1'b1; bus.stop[0] = 1'b1; step(); clear_pulses();
    check("t5_start_wins", 32'(bus.running[0]), 1);
    check("t5_start_wins_ctr", ctr(0), 0);
    step();
    bus.capture[0] = 1'b1; step(); clear_pulses();
`ifdef CAPTURE_FIFO_EN
    check("t5_fifo_head", cap(0), 7);
    check("t5_fifo_ovf", 32'(bus.cap_overflow[0]), 0);
`else
    check("t5_overwrite", cap(0), 1);
    check("t5_ovf", 32'(bus.cap_overflow[0]), 1);
`endif
    bus.rst_capture[0] = 1'b1; bus.capture[0] = 1'b1; step(); clear_pulses();
    check("t5_rstcap_valid", 32'(bus.cap_valid[0]), 0);
    check("t5_rstcap_ovf", 32'(bus.cap_overflow[0]), 0);
    bus.stop[0] = 1'b1; step(); clear_pulses();

    // Periodic alarm on ch3: alarm=3, prescale=0
    bus.mode[3] = 1'b1;
    bus.alarm[3*W +: W] = 8'd3;
    bus.alarm_en[3] = 1'b1;
    bus.start[3] = 1'b1; step(); clear_pulses();
    check("t3_start", ctr(3), 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("t3_ctr%0d", k), ctr(3), (k % 3 == 2) ? 0 : (k % 3) + 1);
      check($sformatf("t3_alarm%0d", k), 32'(bus.alarm_out[3]), (k % 3 == 2) ? 1 : 0);
    end
    bus.alarm_en[3] = 1'b0;
    step(3);
    check("t3_en_off_ctr", ctr(3), 3);
    check("t3_en_off_alarm", 32'(bus.alarm_out[3]), 0);
    bus.stop[3] = 1'b1; step(); clear_pulses();

    // One-shot alarm on ch2 with prescale=3, alarm=4
    bus.prescale = 16'd3;
    bus.mode[2] = 1'b0;
    bus.alarm[2*W +: W] = 8'd4;
    bus.alarm_en[2] = 1'b1;
    bus.start[2] = 1'b1; step(); clear_pulses();
    check("t2_start", ctr(2), 0);
    step(15);
    check("t2_pre_ctr", ctr(2), 3);
    check("t2_pre_alarm", 32'(bus.alarm_out[2]), 0);
    step();
    check("t2_alarm", 32'(bus.alarm_out[2]), 1);
    check("t2_hold", ctr(2), 4);
    check("t2_done", 32'(bus.running[2]), 0);
    step();
    check("t2_pulse_end", 32'(bus.alarm_out[2]), 0);
    check("t2_hold2", ctr(2), 4);
    bus.prescale = '0;
    step(5);

    // Capture depth/overflow on ch1
    bus.start[1] = 1'b1; step(); clear_pulses();
    bus.capture[1] = 1'b1; step(5); clear_pulses();
    check("t4_valid", 32'(bus.cap_valid[1]), 1);
    check("t4_ovf", 32'(bus.cap_overflow[1]), 1);
`ifdef CAPTURE_FIFO_EN
    check("t4_head0", cap(1), 0);
    bus.cap_pop[1] = 1'b1; step(); clear_pulses();
    check("t4_head1", cap(1), 1);
    bus.cap_pop[1] = 1'b1; bus.capture[1] = 1'b1; step(); clear_pulses();
    check("t4_pushpop_head", cap(1), 2);
    check("t4_pushpop_valid", 32'(bus.cap_valid[1]), 1);
`else
    check("t4_last", cap(1), 4);
    bus.cap_pop[1] = 1'b1; step(); clear_pulses();
    check("t4_pop", 32'(bus.cap_valid[1]), 0);
`endif
    bus.rst_capture[1] = 1'b1; step(); clear_pulses();
    check("t4_clr_valid", 32'(bus.cap_valid[1]), 0);
    check("t4_clr_ovf", 32'(bus.cap_overflow[1]), 0);

    // Counter wrap without alarm, then alarm==0 matching on wrap
    bus.alarm_en[1] = 1'b0;
    bus.start[1] = 1'b1; step(); clear_pulses();
    step(256);
    check("wrap_ctr", ctr(1), 0);
    check("wrap_running", 32'(bus.running[1]), 1);
    check("wrap_no_alarm", 32'(bus.alarm_out[1]), 0);
    bus.alarm[1*W +: W] = 8'd0;
    bus.alarm_en[1] = 1'b1;
    step(255);
    check("a0_pre", ctr(1), 255);
    check("a0_pre_alarm", 32'(bus.alarm_out[1]), 0);
    step();
    check("a0_alarm", 32'(bus.alarm_out[1]), 1);
    check("a0_done", 32'(bus.running[1]), 0);
    check("a0_ctr", ctr(1), 0);

    // Asynchronous reset mid-run
    bus.start[0] = 1'b1; bus.start[3] = 1'b1; step(); clear_pulses();
    step(4);
    #3 rst_an = 1'b0;
    #1;
    check("t6_counter", 32'(bus.counter), 0);
    check("t6_running", 32'(bus.running), 0);
    check("t6_alarm", 32'(bus.alarm_out), 0);
    @(posedge clk); #1;
    rst_an = 1'b1;
    step();
    bus.start[0] = 1'b1; step(); clear_pulses();
    check("t6_restart", ctr(0), 0);
    check("t6_run0", 32'(bus.running[0]), 1);
    check("t6_ch3_idle", 32'(bus.running[3]), 0);
    step();
    check("t6_count1", ctr(0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
